// File: rtl/gray_codec_pkg.sv
// Shared constants and helpers for the pipelined binary/Gray codec.
// Width-generic helpers take zero-extended MAX_WIDTH operands; callers truncate the result.
package gray_codec_pkg;

  localparam logic MODE_BIN2GRAY = 1'b0;
  localparam logic MODE_GRAY2BIN = 1'b1;

  localparam int unsigned MAX_WIDTH = 64;

  function automatic int unsigned bits_per_stage(input int unsigned width,
                                                 input int unsigned stages);
    return (width + stages - 1) / stages;
  endfunction

  // Zero extension keeps the MSB rule g[W-1] = b[W-1] for any W <= MAX_WIDTH.
  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_codec_stage.sv
// One valid/ready register stage of gray_codec_pipe.
// Stage 0 fully encodes mode-0 beats; every stage resolves its own MSB-first slice of a decode.
module gray_codec_stage
  import gray_codec_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned STAGE_IDX   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
);

  localparam int Bps   = int'(bits_per_stage(WIDTH, PIPE_STAGES));
  localparam int Hi    = int'(WIDTH) - 1 - int'(STAGE_IDX) * Bps;
  localparam int LoRaw = int'(WIDTH) - (int'(STAGE_IDX) + 1) * Bps;
  localparam int Lo    = (LoRaw < 0) ? 0 : LoRaw;

  logic             valid_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // Load when empty or when the occupant leaves this cycle.
  assign in_ready = !valid_q || out_ready;

  always_comb begin
    data_d = in_data;
    if (in_mode == MODE_GRAY2BIN) begin
      // Bits above the slice are already binary; bits below stay Gray for later stages.
      for (int i = int'(WIDTH) - 2; i >= 0; i--) begin
        if (i <= Hi && i >= Lo) begin
          data_d[i] = data_d[i+1] ^ data_d[i];
        end
      end
    end else if (STAGE_IDX == 0) begin
      data_d = WIDTH'(bin2gray(MAX_WIDTH'(in_data)));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      mode_q  <= MODE_BIN2GRAY;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        mode_q <= in_mode;
        data_q <= data_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_mode  = mode_q;
  assign out_data  = data_q;

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined bidirectional binary/Gray converter with valid/ready flow control.
// Define GRAY_CODEC_ADJ_CHECK_EN to add the sticky adj_err check on mode-1 input beats.
module gray_codec_pipe
  import gray_codec_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data
`ifdef GRAY_CODEC_ADJ_CHECK_EN
  ,
  output logic             adj_err
`endif
);

  // Index k is the input of stage k; index PIPE_STAGES is the block output.
  logic             vld [PIPE_STAGES+1];
  logic             rdy [PIPE_STAGES+1];
  logic             md  [PIPE_STAGES+1];
  logic [WIDTH-1:0] dat [PIPE_STAGES+1];

  assign vld[0]           = in_valid;
  assign md[0]            = in_mode;
  assign dat[0]           = in_data;
  assign in_ready         = rdy[0];
  assign rdy[PIPE_STAGES] = out_ready;
  assign out_valid        = vld[PIPE_STAGES];
  assign out_mode         = md[PIPE_STAGES];
  assign out_data         = dat[PIPE_STAGES];

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    gray_codec_stage #(
      .WIDTH      (WIDTH),
      .PIPE_STAGES(PIPE_STAGES),
      .STAGE_IDX  (k)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_mode  (md[k]),
      .in_data  (dat[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_mode (md[k+1]),
      .out_data (dat[k+1])
    );
  end

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q;
  logic             adj_err_q;
  logic             g2b_accept;

  assign g2b_accept = in_valid && in_ready && (in_mode == MODE_GRAY2BIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      adj_err_q   <= 1'b0;
    end else if (g2b_accept) begin
      prev_q      <= in_data;
      have_prev_q <= 1'b1;
      // Repeats (zero bits changed) are flagged as well as multi-bit jumps.
      if (have_prev_q && ($countones(in_data ^ prev_q) != 1)) begin
        adj_err_q <= 1'b1;
      end
    end
  end

  assign adj_err = adj_err_q;
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed self-checking bench for gray_codec_pipe (WIDTH=8, depths 2, 1, 3 and 8).
// Adjacency-check steps are compiled in with GRAY_CODEC_ADJ_CHECK_EN.
module tb_gray_codec_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_mode = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_mode;
  logic [7:0] out_data;

  logic       x_valid = 1'b0;
  logic       x_mode = 1'b0;
  logic [7:0] x_data = 8'h00;
  logic       x_rdy1, x_rdy3, x_rdy8;
  logic       x_ov1, x_ov3, x_ov8;
  logic       x_om1, x_om3, x_om8;
  logic [7:0] x_od1, x_od3, x_od8;

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  logic adj_err, x_ae1, x_ae3, x_ae8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_codec_pipe #(.WIDTH(8), .PIPE_STAGES(2)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data)
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    , .adj_err(adj_err)
`endif
  );

  gray_codec_pipe #(.WIDTH(8), .PIPE_STAGES(1)) u_p1 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_rdy1), .in_mode(x_mode),
    .in_data(x_data), .out_valid(x_ov1), .out_ready(1'b1), .out_mode(x_om1), .out_data(x_od1)
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    , .adj_err(x_ae1)
`endif
  );

  gray_codec_pipe #(.WIDTH(8), .PIPE_STAGES(3)) u_p3 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_rdy3), .in_mode(x_mode),
    .in_data(x_data), .out_valid(x_ov3), .out_ready(1'b1), .out_mode(x_om3), .out_data(x_od3)
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    , .adj_err(x_ae3)
`endif
  );

  gray_codec_pipe #(.WIDTH(8), .PIPE_STAGES(8)) u_p8 (
    .clk(clk), .rst(rst), .in_valid(x_valid), .in_ready(x_rdy8), .in_mode(x_mode),
    .in_data(x_data), .out_valid(x_ov8), .out_ready(1'b1), .out_mode(x_om8), .out_data(x_od8)
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    , .adj_err(x_ae8)
`endif
  );

  function automatic logic [7:0] gray8(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR form of the decode: b[i] = XOR of g[j] for all j >= i.
  function automatic logic [7:0] bin8(input logic [7:0] g);
    logic [7:0] b;
    b = g;
    for (int s = 1; s < 8; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated beat with out_ready high: output must appear exactly 2 cycles after accept.
  task automatic send_one(input string tag, input logic m, input logic [7:0] d,
                          input logic [7:0] e);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, out_valid, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, e);
    chk({tag, "_mode"}, out_mode, m);
    @(posedge clk); #1;
  endtask

  task automatic chk_x(input string tag, input logic v, input logic m, input logic [7:0] d,
                       inout int cnt);
    logic [7:0] e;
    if (v) begin
      e = cnt[0] ? 8'(cnt >> 1) : gray8(8'(cnt >> 1));
      chk({tag, "_mode"}, m, cnt[0]);
      chk({tag, "_data"}, d, e);
      cnt++;
    end
  endtask

`ifdef GRAY_CODEC_ADJ_CHECK_EN
  task automatic adj_beat(input string tag, input logic m, input logic [7:0] d,
                          input logic e);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_mode   = m;
    in_data   = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk(tag, adj_err, e);
  endtask
`endif

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Stream 0x00..0x0F, mode = index LSB; hand-derived conversions.
  logic [7:0] bp_exp [16] = '{8'h00, 8'h01, 8'h03, 8'h02, 8'h06, 8'h06, 8'h05, 8'h05,
                              8'h0C, 8'h0E, 8'h0F, 8'h0D, 8'h0A, 8'h09, 8'h09, 8'h0A};

  initial begin
    int sent, got, first, last, r1, r3, r8;
    logic [7:0] d, e;

    #22 rst = 1'b0;
    @(posedge clk); #1;

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_mode", out_mode, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef GRAY_CODEC_ADJ_CHECK_EN
    chk("rst_adj_err", adj_err, 0);
`endif

    send_one("enc_5a", 1'b0, 8'h5A, 8'h77);
    send_one("enc_ff", 1'b0, 8'hFF, 8'h80);
    send_one("dec_77", 1'b1, 8'h77, 8'h5A);
    send_one("dec_80", 1'b1, 8'h80, 8'hFF);

    // Backpressure: out_ready low in cycles 3..5.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 60 && got < 16; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 16);
      in_mode   = sent[0];
      in_data   = 8'(sent);
      @(negedge clk);
      if (c == 4) begin
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_hold_valid", out_valid, 1);
        chk("bp_hold_data", out_data, bp_exp[1]);
        chk("bp_hold_mode", out_mode, 1);
      end
      if (out_valid && out_ready) begin
        chk("bp_data", out_data, bp_exp[got]);
        chk("bp_mode", out_mode, got[0]);
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", got, 16);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("bp_no_dup", out_valid, 0);
      @(posedge clk); #1;
    end

    // Reset with two beats in flight.
    in_valid = 1'b1;
    in_mode  = 1'b0;
    in_data  = 8'h10;
    @(posedge clk); #1;
    in_data = 8'h20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_pre_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_async_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_flushed", out_valid, 0);
    @(posedge clk); #1;
    send_one("mid_first", 1'b0, 8'h01, 8'h01);

    // Full throughput: 64 beats, no bubbles.
    sent  = 0;
    got   = 0;
    first = -1;
    last  = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && got < 64; c++) begin
      in_valid = (sent < 64);
      in_mode  = sent[0];
      in_data  = 8'(sent * 37 + 11);
      @(negedge clk);
      if (in_valid) chk("tp_in_ready", in_ready, 1);
      if (out_valid) begin
        d = 8'(got * 37 + 11);
        e = got[0] ? bin8(d) : gray8(d);
        chk("tp_data", out_data, e);
        chk("tp_mode", out_mode, got[0]);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("tp_count", got, 64);
    chk("tp_first_latency", first, 2);
    chk("tp_no_bubbles", last - first, 63);

    // Exhaustive round trip on depths 1, 3 and 8.
    r1 = 0;
    r3 = 0;
    r8 = 0;
    for (int i = 0; i < 530; i++) begin
      x_valid = (i < 512);
      x_mode  = i[0];
      x_data  = i[0] ? gray8(8'(i >> 1)) : 8'(i >> 1);
      @(negedge clk);
      chk_x("rt_p1", x_ov1, x_om1, x_od1, r1);
      chk_x("rt_p3", x_ov3, x_om3, x_od3, r3);
      chk_x("rt_p8", x_ov8, x_om8, x_od8, r8);
      @(posedge clk); #1;
    end
    chk("rt_p1_count", r1, 512);
    chk("rt_p3_count", r3, 512);
    chk("rt_p8_count", r8, 512);
    chk("rt_rdy", {x_rdy1, x_rdy3, x_rdy8}, 3'b111);

`ifdef GRAY_CODEC_ADJ_CHECK_EN
    pulse_reset();
    chk("adj_after_rst", adj_err, 0);
    adj_beat("adj_00", 1'b1, 8'h00, 1'b0);
    adj_beat("adj_01", 1'b1, 8'h01, 1'b0);
    adj_beat("adj_03", 1'b1, 8'h03, 1'b0);
    adj_beat("adj_mode0_skip", 1'b0, 8'hF0, 1'b0);
    adj_beat("adj_07", 1'b1, 8'h07, 1'b0);
    adj_beat("adj_jump", 1'b1, 8'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("adj_sticky", adj_err, 1);
    adj_beat("adj_sticky_adj", 1'b1, 8'h01, 1'b1);
    pulse_reset();
    chk("adj_cleared", adj_err, 0);
    adj_beat("adj_05a", 1'b1, 8'h05, 1'b0);
    adj_beat("adj_05b", 1'b1, 8'h05, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
Parametrised, pipelined successor to the team's single-direction binary-to-Gray encoder. Converts per transaction in either direction, binary-to-Gray or Gray-to-binary, using a per-beat mode bit. Streams through a valid/ready pipeline of configurable depth with full backpressure. Sits between counter/pointer logic and CDC or encoder paths that exchange Gray-coded values.

Parameters:
WIDTH, 8, data width in bits; must be >= 2.
PIPE_STAGES, 2, number of register stages; 1 <= PIPE_STAGES <= WIDTH; equals latency in cycles.

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept input this cycle
in_mode  input  1  0 = binary-to-Gray, 1 = Gray-to-binary
in_data  input  WIDTH  value to convert
out_valid  output  1  output beat valid
out_ready  input  1  downstream accepts output
out_mode  output  1  mode of the beat on out_data
out_data  output  WIDTH  converted value

Behaviour:
- Reset (async assert, sync-released use): all stage valid bits = 0, out_valid = 0, out_data = 0, out_mode = 0. in_ready is high after reset because the pipeline is empty.
- Handshake: input accepted when in_valid && in_ready; output transferred when out_valid && out_ready. out_data and out_mode hold stable while out_valid && !out_ready.
- Stall: stage k advances when its successor is empty or advancing. in_ready = !v[0] || stage0_advance. Stages form a combinational ready chain with no bubbles; sustained throughput is 1 beat/cycle when out_ready = 1.
- Latency: an accepted beat appears on out_valid exactly PIPE_STAGES cycles later if never stalled.
- Binary-to-Gray (mode 0): g[WIDTH-1] = b[WIDTH-1]; g[i] = b[i] ^ b[i+1]. Computed fully in stage 0; later stages pass it through.
- Gray-to-binary (mode 1): b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i]. This is a serial XOR chain, so it is split across stages, MSB first.
  - Stage k resolves bits in slice k, with BITS_PER_STAGE = ceil(WIDTH/PIPE_STAGES).
  - Each stage carries the partially converted word plus the untouched Gray bits.
  - The last stage may hold fewer bits.
- Mode travels with its beat. Mixed-mode back-to-back beats are legal and must not interfere.
- No data loss or duplication under any out_ready pattern.
- Simultaneous accept at input and output in the same cycle: both occur; occupancy is unchanged.
- Reset mid-stream: all in-flight beats are discarded. out_valid drops asynchronously.

Optional Feature:
Macro GRAY_CODEC_ADJ_CHECK_EN.
- Defined: adds output adj_err (1 bit, reset 0), a sticky flag.
  - The block records the last accepted in_data with in_mode = 1, plus a "have_prev" bit; both clear on reset.
  - On each later accepted mode-1 beat, if popcount(in_data ^ prev) != 1, adj_err sets one cycle after acceptance.
  - Identical consecutive values count as an error.
  - Mode-0 beats neither compare nor update prev.
  - adj_err clears only on rst.
- Undefined: no port, no registers. Datapath behaviour is identical.

Decomposition:
- Shared package gray_codec_pkg holds:
  - Mode constants MODE_BIN2GRAY = 1'b0 and MODE_GRAY2BIN = 1'b1.
  - A function bin2gray(WIDTH-generic via parameterised length).
  - The BITS_PER_STAGE computation.
- One sub-module, gray_codec_stage: a single valid/ready register stage parameterised by stage index. It resolves its bit slice and handles its stall logic. The top instantiates PIPE_STAGES of them in a generate loop, plus the optional checker.

Test Plan (WIDTH=8, PIPE_STAGES=2 unless noted):
- Encode: mode 0, data 0x5A, out_ready=1 -> out_data 0x77, mode 0, 2 cycles after accept. Also 0xFF -> 0x80.
- Decode: mode 1, data 0x77 -> 0x5A; 0x80 -> 0xFF. Exhaustive 0..255 round trip for PIPE_STAGES = 1, 3, 8: decode(encode(x)) == x.
- Backpressure: stream 0x00..0x0F alternating modes, out_ready low for cycles 3-5 -> in_ready drops when 2 beats are held, output order and values exact, no duplicates.
- Reset mid-stream: assert rst with 2 beats in flight -> out_valid=0 immediately. After release, the first new beat 0x01 (mode 0) -> 0x01 with correct latency.
- Full throughput: 64 beats with in_valid and out_ready held high -> one output per cycle, no bubbles.
- With GRAY_CODEC_ADJ_CHECK_EN: mode-1 beats 0x00, 0x01, 0x03 -> adj_err stays 0. Then 0x00 -> adj_err=1 and stays 1. Separately, 0x05, 0x05 -> adj_err=1.
